// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window feeder: default widths,
// FSM state encoding and the PE result latency.
package conv_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 32;
    // Edges from the PE sampling pe_start to pe_done rising.
    localparam int PE_DONE_LAT = 2;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_FIRE    = 3'd1,
        S_WAIT    = 3'd2,
        S_OUT     = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixels: combinational read and synchronous write,
// both at the same column address.
module conv_line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [AW-1:0]           addr,
    input  logic signed [WIDTH-1:0] wr_data,
    output logic signed [WIDTH-1:0] rd_data
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; row/col gating guarantees every
    // location is written before its contents reach a window that is fired.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Read sees the old word during a same-cycle write, which is what the
    // row shift relies on.
    assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_feeder.sv
// Builds 3x3 valid-convolution windows from a raster pixel stream, drives
// the PE start/done handshake and returns each result on a valid/ready port.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    input  logic signed [DATA_W-1:0] pix_data,
    output logic                     pix_ready,
    output logic signed [DATA_W-1:0] win_0,
    output logic signed [DATA_W-1:0] win_1,
    output logic signed [DATA_W-1:0] win_2,
    output logic signed [DATA_W-1:0] win_3,
    output logic signed [DATA_W-1:0] win_4,
    output logic signed [DATA_W-1:0] win_5,
    output logic signed [DATA_W-1:0] win_6,
    output logic signed [DATA_W-1:0] win_7,
    output logic signed [DATA_W-1:0] win_8,
    output logic                     pe_start,
    input  logic                     pe_done,
    input  logic signed [ACC_W-1:0]  pe_result,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    input  logic                     out_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t                   state, state_nx;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [DATA_W-1:0] win [9];
    logic signed [DATA_W-1:0] lb0_rd, lb1_rd;
    logic                     accept, win_done, last_win;

    assign accept   = pix_valid && pix_ready;
    assign win_done = (row >= RW'(2)) && (col >= CW'(2));

    // lb0 holds row r-2, lb1 holds row r-1; an accept moves each column up one row.
    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (pix_data),
        .rd_data (lb1_rd)
    );

    // NOTE: state-holding processes use non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        pix_ready = 1'b0;
        pe_start  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_LOAD: begin
                pix_ready = !rst;
                if (accept && win_done) state_nx = S_FIRE;
            end
            S_FIRE: begin
                pe_start = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT:    if (pe_done) state_nx = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_RELEASE;
            end
            S_RELEASE: if (!pe_done) state_nx = S_LOAD;
            default:   state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            last_win <= 1'b0;
        end else if (accept) begin
            last_win <= (row == ROW_LAST) && (col == COL_LAST);
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Each window row shifts left; the new right column comes from the line buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]   <= win[3*r+1];
                win[3*r+1] <= win[3*r+2];
            end
            win[2] <= lb0_rd;
            win[5] <= lb1_rd;
            win[8] <= pix_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_last <= 1'b0;
        end else if (state == S_WAIT && pe_done) begin
            out_data <= pe_result;
            out_last <= last_win;
        end
    end

    assign win_0 = win[0];
    assign win_1 = win[1];
    assign win_2 = win[2];
    assign win_3 = win[3];
    assign win_4 = win[4];
    assign win_5 = win[5];
    assign win_6 = win[6];
    assign win_7 = win[7];
    assign win_8 = win[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 4x4 frame with a behavioural
// 3x3 PE (configurable uniform filter) attached.
module tb_conv_window_feeder;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int NPIX = W * H;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pix_valid = 1'b0;
    logic signed [7:0]  pix_data = '0;
    logic               pix_ready;
    logic signed [7:0]  w [9];
    logic               pe_start;
    logic               pe_done;
    logic signed [31:0] pe_result;
    logic               out_valid;
    logic signed [31:0] out_data;
    logic               out_last;
    logic               out_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int filt  = 1;
    int cyc   = 0;
    int n_start = 0;
    int n_dbl   = 0;
    logic prev_start = 1'b0;
    int acc_cyc [NPIX];

    int fr_inc [NPIX];
    int fr_dec [NPIX];
    int fr_neg [NPIX];
    int ex_inc [4];
    int ex_dec [4];
    int ex_neg [4];

    conv_window_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .ACC_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .win_0     (w[0]),
        .win_1     (w[1]),
        .win_2     (w[2]),
        .win_3     (w[3]),
        .win_4     (w[4]),
        .win_5     (w[5]),
        .win_6     (w[6]),
        .win_7     (w[7]),
        .win_8     (w[8]),
        .pe_start  (pe_start),
        .pe_done   (pe_done),
        .pe_result (pe_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Behavioural PE: samples the window with pe_start, raises done
    // PE_DONE_LAT edges later and holds it for two cycles.
    int pe_cnt;
    int pe_acc;

    function automatic int pe_sum();
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(w[i]) * filt;
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_done   <= 1'b0;
            pe_result <= '0;
            pe_cnt    <= 0;
            pe_acc    <= 0;
        end else if (pe_cnt == 0) begin
            if (pe_start) begin
                pe_cnt <= 1;
                pe_acc <= pe_sum();
            end
        end else if (pe_cnt == PE_DONE_LAT - 1) begin
            pe_done   <= 1'b1;
            pe_result <= pe_acc;
            pe_cnt    <= pe_cnt + 1;
        end else if (pe_cnt == PE_DONE_LAT + 1) begin
            pe_done <= 1'b0;
            pe_cnt  <= 0;
        end else begin
            pe_cnt <= pe_cnt + 1;
        end
    end

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        prev_start <= pe_start;
        if (pe_start) n_start <= n_start + 1;
        if (pe_start && prev_start) n_dbl <= n_dbl + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents pixel k and returns on the negedge after it is accepted.
    task automatic accept_pix(input int d, input int k);
        bit ok = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 8'(d);
        for (int i = 0; i < 40; i++) begin
            if (pix_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check($sformatf("pix%0d_ready_timeout", k), 32'(pix_ready), 32'sd1);
        acc_cyc[k] = cyc;
        @(negedge clk);
    endtask

    task automatic wait_out(input int exp, input bit last, input bit stall, input string tag);
        int s0;
        if (stall) out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(out_valid), 32'sd1);
        check({tag, "_data"},  out_data, 32'(exp));
        check({tag, "_last"},  32'(out_last), 32'(last));
        if (stall) begin
            s0 = n_start;
            for (int i = 0; i < 5; i++) begin
                check($sformatf("%s_hold%0d_valid", tag, i), 32'(out_valid), 32'sd1);
                check($sformatf("%s_hold%0d_data", tag, i), out_data, 32'(exp));
                check($sformatf("%s_hold%0d_ready", tag, i), 32'(pix_ready), 32'sd0);
                @(negedge clk);
            end
            check({tag, "_no_extra_start"}, 32'(n_start), 32'(s0));
            out_ready = 1'b1;
        end
    endtask

    // Streams one frame with pix_valid held high, checking each result.
    task automatic run_frame(input int px [NPIX], input int ex [4], input bit stall,
                             input string tag);
        int n = 0;
        for (int k = 0; k < NPIX; k++) begin
            accept_pix(px[k], k);
            if ((k / W) >= 2 && (k % W) >= 2) begin
                check($sformatf("%s_w%0d_ready_low", tag, n), 32'(pix_ready), 32'sd0);
                check($sformatf("%s_w%0d_start", tag, n), 32'(pe_start), 32'sd1);
                if (k < NPIX - 1) pix_data = 8'(px[k+1]);
                else pix_valid = 1'b0;
                wait_out(ex[n], n == 3, stall && n == 0, $sformatf("%s_out%0d", tag, n));
                n++;
            end
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        for (int k = 0; k < NPIX; k++) begin
            fr_inc[k] = k + 1;
            fr_dec[k] = NPIX - k;
            fr_neg[k] = -128;
        end
        ex_inc = '{54, 63, 90, 99};
        ex_dec = '{99, 90, 63, 54};
        ex_neg = '{-146304, -146304, -146304, -146304};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 32'sd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pix_ready", 32'(pix_ready), 32'sd1);
        check("post_rst_out_valid", 32'(out_valid), 32'sd0);
        check("post_rst_pe_start", 32'(pe_start), 32'sd0);
        check("post_rst_out_data", out_data, 32'sd0);
        check("post_rst_out_last", 32'(out_last), 32'sd0);
        check("post_rst_win8", w[8], 32'sd0);

        // 1: basic frame
        run_frame(fr_inc, ex_inc, 1'b0, "t1");

        // 2: continuous pix_valid, burst timing and single-cycle start
        s0 = n_start;
        run_frame(fr_inc, ex_inc, 1'b0, "t2");
        check("t2_burst_cycles", 32'(acc_cyc[10] - acc_cyc[0]), 32'sd10);
        check("t2_window_gap", 32'(acc_cyc[11] - acc_cyc[10]), 32'sd6);
        check("t2_start_count", 32'(n_start - s0), 32'sd4);
        check("t2_start_double", 32'(n_dbl), 32'sd0);

        // 3: downstream stall on first result
        run_frame(fr_inc, ex_inc, 1'b1, "t3");

        // 4: reset while waiting on the second window
        for (int k = 0; k < 12; k++) accept_pix(fr_inc[k], k);
        pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_out_valid", 32'(out_valid), 32'sd0);
        check("t4_rst_out_data", out_data, 32'sd0);
        check("t4_rst_out_last", 32'(out_last), 32'sd0);
        check("t4_rst_pe_start", 32'(pe_start), 32'sd0);
        check("t4_rst_pix_ready", 32'(pix_ready), 32'sd0);
        check("t4_rst_win0", w[0], 32'sd0);
        check("t4_rst_win4", w[4], 32'sd0);
        check("t4_rst_win8", w[8], 32'sd0);
        rst = 1'b0;
        @(negedge clk);
        run_frame(fr_inc, ex_inc, 1'b0, "t4");

        // 5: back-to-back frames with different contents
        run_frame(fr_dec, ex_dec, 1'b0, "t5a");
        run_frame(fr_inc, ex_inc, 1'b0, "t5b");

        // 6: most negative pixels with a large filter
        filt = 127;
        run_frame(fr_neg, ex_neg, 1'b0, "t6");

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
